stream_demux_1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the routing counterpart of the team's 4-bit 2:1 select muxes.
- Steers each input word to output channel A (in_sel=0) or B (in_sel=1).
- Each channel has its own DEPTH-entry FIFO, so a stalled channel never blocks traffic to the other channel once that channel has space.
- Sits between a shared producer and two independent consumers, with valid/ready handshakes on all sides.

---
 rtl/stream_demux_1to2_if.sv | 28 ++
 rtl/stream_demux_1to2.sv | 91 +++++++++
 tb/tb_stream_demux_1to2.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1to2_if.sv
// rtl/stream_demux_1to2_if.sv - handshake bundle for the 1-to-2 stream demultiplexer
interface stream_demux_1to2_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - registered 1-to-2 stream demux with per-channel FIFOs and counters
module stream_demux_1to2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  stream_demux_1to2_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Index 0 is channel A, index 1 is channel B throughout.
  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PTR_W-1:0] wptr_q [2];
  logic [PTR_W-1:0] wptr_d [2];
  logic [PTR_W-1:0] rptr_q [2];
  logic [PTR_W-1:0] rptr_d [2];
  logic [OCC_W-1:0] occ_q  [2];
  logic [OCC_W-1:0] occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready;
  logic             in_ready;

  always_comb begin
    out_ready = {bus.b_ready, bus.a_ready};
    full      = '0;
    empty     = '0;
    push      = '0;
    pop       = '0;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    for (int c = 0; c < 2; c++) begin
      full[c]  = (occ_q[c] == OCC_FULL);
      empty[c] = (occ_q[c] == '0);
    end
    // Readiness looks only at registered occupancy, never at the sink readies.
    in_ready = rst_n && !full[bus.in_sel];
    for (int c = 0; c < 2; c++) begin
      push[c] = bus.in_valid && in_ready && (bus.in_sel == 1'(c));
      pop[c]  = !empty[c] && out_ready[c];
      if (push[c]) wptr_d[c] = wptr_q[c] + PTR_W'(1);
      if (pop[c])  rptr_d[c] = rptr_q[c] + PTR_W'(1);
      if (push[c] && !pop[c])      occ_d[c] = occ_q[c] + OCC_W'(1);
      else if (pop[c] && !push[c]) occ_d[c] = occ_q[c] - OCC_W'(1);
      if (pop[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  // Storage needs no reset: push is already blocked while rst_n is low.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.a_valid  = !empty[0];
  assign bus.b_valid  = !empty[1];
  assign bus.a_data   = empty[0] ? '0 : mem_q[0][rptr_q[0]];
  assign bus.b_data   = empty[1] ? '0 : mem_q[1][rptr_q[1]];
  assign bus.a_count  = cnt_q[0];
  assign bus.b_count  = cnt_q[1];
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb/tb_stream_demux_1to2.sv - self-checking bench for stream_demux_1to2
module tb_stream_demux_1to2;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_sel;
  logic       a_ready;
  logic       b_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: one queue per channel plus raw delivered counts.
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int         dela = 0;
  int         delb = 0;
  bit         known = 1'b0;
  logic       seen_ready;

  always #5 clk = ~clk;

  stream_demux_1to2_if #(.WIDTH(4), .CNT_W(8)) bus8 ();
  stream_demux_1to2_if #(.WIDTH(4), .CNT_W(3)) bus3 ();

  assign bus8.in_valid = in_valid;
  assign bus8.in_data  = in_data;
  assign bus8.in_sel   = in_sel;
  assign bus8.a_ready  = a_ready;
  assign bus8.b_ready  = b_ready;
  assign bus3.in_valid = in_valid;
  assign bus3.in_data  = in_data;
  assign bus3.in_sel   = in_sel;
  assign bus3.a_ready  = a_ready;
  assign bus3.b_ready  = b_ready;

  stream_demux_1to2 #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  stream_demux_1to2 #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(3)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic       e_rdy;
    logic       acc;
    logic       pa;
    logic       pb;
    logic [3:0] tmp;
    @(negedge clk);
    e_rdy = rst_n && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    seen_ready = bus8.in_ready;
    chk("in_ready", {31'd0, bus8.in_ready}, {31'd0, e_rdy});
    chk("in_ready_c3", {31'd0, bus3.in_ready}, {31'd0, e_rdy});
    if (known) begin
      chk("a_valid", {31'd0, bus8.a_valid}, (qa.size() > 0) ? 1 : 0);
      chk("b_valid", {31'd0, bus8.b_valid}, (qb.size() > 0) ? 1 : 0);
      chk("a_data", {28'd0, bus8.a_data}, (qa.size() > 0) ? {28'd0, qa[0]} : 0);
      chk("b_data", {28'd0, bus8.b_data}, (qb.size() > 0) ? {28'd0, qb[0]} : 0);
      chk("a_count", {24'd0, bus8.a_count}, sat(dela, 255));
      chk("b_count", {24'd0, bus8.b_count}, sat(delb, 255));
      chk("a_count_c3", {29'd0, bus3.a_count}, sat(dela, 7));
      chk("b_count_c3", {29'd0, bus3.b_count}, sat(delb, 7));
    end
    acc = in_valid && e_rdy;
    pa  = (qa.size() > 0) && a_ready;
    pb  = (qb.size() > 0) && b_ready;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      dela  = 0;
      delb  = 0;
      known = 1'b1;
    end else begin
      if (pa) begin tmp = qa.pop_front(); dela++; end
      if (pb) begin tmp = qb.pop_front(); delb++; end
      if (acc) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic s, input logic ar, input logic br);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    a_ready  = ar;
    b_ready  = br;
    cycle();
  endtask

  task automatic idle(input logic ar, input logic br);
    in_valid = 1'b0;
    in_data  = 4'h0;
    a_ready  = ar;
    b_ready  = br;
    cycle();
  endtask

  initial begin
    // Reset held with a word offered.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h5; in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    repeat (3) cycle();
    chk("rst_in_ready", {31'd0, seen_ready}, 0);
    chk("rst_a_count", {24'd0, bus8.a_count}, 0);
    rst_n = 1'b1;
    idle(1'b1, 1'b1);
    chk("rel_in_ready", {31'd0, seen_ready}, 1);
    chk("rel_a_valid", {31'd0, bus8.a_valid}, 0);

    // Basic routing.
    send(4'h3, 1'b0, 1'b1, 1'b1);
    send(4'hA, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("route_a_count", {24'd0, bus8.a_count}, 1);
    chk("route_b_count", {24'd0, bus8.b_count}, 1);

    // Backpressure on A, B stays open.
    send(4'h1, 1'b0, 1'b0, 1'b1);
    chk("bp_acc_1", {31'd0, seen_ready}, 1);
    send(4'h2, 1'b0, 1'b0, 1'b1);
    chk("bp_acc_2", {31'd0, seen_ready}, 1);
    send(4'h3, 1'b0, 1'b0, 1'b1);
    chk("bp_rej_3", {31'd0, seen_ready}, 0);
    send(4'h7, 1'b1, 1'b0, 1'b1);
    chk("iso_acc_7", {31'd0, seen_ready}, 1);
    idle(1'b0, 1'b1);
    // Full channel with sink ready: reject this cycle, accept the next.
    send(4'h3, 1'b0, 1'b1, 1'b1);
    chk("full_rdy_rej", {31'd0, seen_ready}, 0);
    send(4'h3, 1'b0, 1'b1, 1'b1);
    chk("full_rdy_acc", {31'd0, seen_ready}, 1);
    repeat (3) idle(1'b1, 1'b1);
    chk("bp_a_count", {24'd0, bus8.a_count}, 4);

    // Streaming across pointer wrap, from a clean count.
    rst_n = 1'b0;
    idle(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(4'(i), 1'b1, 1'b1, 1'b1);
      chk("stream_ready", {31'd0, seen_ready}, 1);
    end
    repeat (2) idle(1'b1, 1'b1);
    chk("stream_b_count", {24'd0, bus8.b_count}, 20);

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 10; i++) send(4'(i + 3), 1'b0, 1'b1, 1'b1);
    repeat (2) idle(1'b1, 1'b1);
    chk("sat_a_count_c3", {29'd0, bus3.a_count}, 7);
    chk("sat_a_count", {24'd0, bus8.a_count}, 10);
    send(4'h9, 1'b0, 1'b0, 1'b0);
    send(4'h8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    send(4'h6, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    idle(1'b0, 1'b0);
    chk("midrst_a_valid", {31'd0, bus3.a_valid}, 0);
    chk("midrst_a_count_c3", {29'd0, bus3.a_count}, 0);

    // Randomized traffic, including sel changes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      in_sel   = 1'($urandom_range(0, 1));
      a_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst_n = 1'b1;
    repeat (4) idle(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
